// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one combinational byte-lane memory.
// Each port owns a single response slot; the fetch port is protected from starvation.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_addr,
  output logic        i_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] i_resp_data,
  output logic        i_resp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_we,
  input  logic [2:0]  d_mode,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_resp_valid,
  input  logic        d_resp_ready,
  output logic [31:0] d_resp_data,
  output logic        d_resp_err,
  output logic        mem_we,
  output logic [2:0]  mem_mode,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] MODE_BYTE = 3'b001;
  localparam logic [2:0] MODE_HALF = 3'b010;
  localparam logic [2:0] MODE_WORD = 3'b100;
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } slot_t;

  slot_t            i_slot, d_slot;
  logic [CNT_W-1:0] starve_cnt;
  logic             i_elig, d_elig, grant_i, grant_d, i_mis, d_mis;

  function automatic logic data_misaligned(input logic [2:0] mode, input logic [1:0] lsb);
    case (mode)
      MODE_BYTE: return 1'b0;
      MODE_HALF: return lsb[0];
      MODE_WORD: return lsb != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

  assign i_mis = i_addr[1:0] != 2'b00;
  assign d_mis = data_misaligned(d_mode, d_addr[1:0]);

  // Gating eligibility with rst blocks every grant, and therefore every memory write, during reset.
  assign i_elig  = i_req_valid && !i_slot.valid && !rst;
  assign d_elig  = d_req_valid && !d_slot.valid && !rst;
  assign grant_i = i_elig && (!d_elig || starve_cnt >= LIMIT);
  assign grant_d = d_elig && !grant_i;

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  // A slot loaded just before reset must not be presented while reset is held.
  assign i_resp_valid = i_slot.valid && !rst;
  assign i_resp_data  = i_slot.data;
  assign i_resp_err   = i_slot.err;
  assign d_resp_valid = d_slot.valid && !rst;
  assign d_resp_data  = d_slot.data;
  assign d_resp_err   = d_slot.err;

  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    mem_we      = 1'b0;
    mem_mode    = 3'b000;
    mem_address = 32'h0;
    mem_wdata   = 32'h0;
    if (grant_i) begin
      mem_address = i_addr;
      mem_mode    = MODE_WORD;
    end else if (grant_d) begin
      mem_address = d_addr;
      mem_mode    = d_mode;
      mem_wdata   = d_wdata;
      mem_we      = d_we && !d_mis;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is a branch inside the clocked block, not a sensitivity entry.
    if (rst) begin
      i_slot     <= '0;
      d_slot     <= '0;
      starve_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
      if (grant_i) begin
        i_slot <= '{valid: 1'b1, err: i_mis, data: i_mis ? 32'h0 : mem_rdata};
      end else if (i_slot.valid && i_resp_ready) begin
        i_slot.valid <= 1'b0;
      end

      if (grant_d) begin
        d_slot <= '{valid: 1'b1, err: d_mis, data: (d_mis || d_we) ? 32'h0 : mem_rdata};
      end else if (d_slot.valid && d_resp_ready) begin
        d_slot.valid <= 1'b0;
      end

      if (i_elig && !grant_i) begin
        if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed multi-cycle sequences, then random traffic
// checked against a rule-level model with its own shadow copy of memory.
module tb_mem_arbiter;

  localparam int unsigned STARVE = 3;
  localparam int          N_RAND = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_ready, i_resp_err;
  logic [31:0] i_addr, i_resp_data;
  logic        d_req_valid, d_req_ready, d_we, d_resp_valid, d_resp_ready, d_resp_err;
  logic [2:0]  d_mode;
  logic [31:0] d_addr, d_wdata, d_resp_data;
  logic        mem_we;
  logic [2:0]  mem_mode;
  logic [31:0] mem_address, mem_wdata, mem_rdata;

  logic [7:0] phys   [256];
  logic [7:0] shadow [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
    .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_mode(d_mode),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
    .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .mem_we(mem_we), .mem_mode(mem_mode), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h10: return 8'h78;
      'h11: return 8'h56;
      'h12: return 8'h34;
      'h13: return 8'h12;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  // Byte and halfword reads come back sign-extended from the memory itself.
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] mode);
    case (mode)
      3'b001:  return {{24{raw[7]}}, raw[7:0]};
      3'b010:  return {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always_comb begin
    mem_rdata = extend({phys[mem_address[7:0] + 8'd3], phys[mem_address[7:0] + 8'd2],
                        phys[mem_address[7:0] + 8'd1], phys[mem_address[7:0]]}, mem_mode);
  end

  initial begin
    for (int i = 0; i < 256; i++) phys[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (mem_we) begin
        phys[mem_address[7:0]] <= mem_wdata[7:0];
        if (mem_mode != 3'b001) phys[mem_address[7:0] + 8'd1] <= mem_wdata[15:8];
        if (mem_mode == 3'b100) begin
          phys[mem_address[7:0] + 8'd2] <= mem_wdata[23:16];
          phys[mem_address[7:0] + 8'd3] <= mem_wdata[31:24];
        end
      end
    end
  end

  // ---------------- reference model helpers ----------------
  function automatic int size_of(input logic [2:0] mode);
    case (mode)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic model_mis(input logic [31:0] addr, input logic [2:0] mode);
    int s;
    s = size_of(mode);
    if (s == 0) return 1'b1;
    return (addr % s) != 0;
  endfunction

  function automatic logic [31:0] shadow_read(input logic [31:0] addr, input logic [2:0] mode);
    logic [7:0] a;
    a = addr[7:0];
    return extend({shadow[a + 8'd3], shadow[a + 8'd2], shadow[a + 8'd1], shadow[a]}, mode);
  endfunction

  task automatic shadow_write(input logic [31:0] addr, input logic [2:0] mode,
                              input logic [31:0] data);
    for (int k = 0; k < size_of(mode); k++) shadow[8'(addr[7:0] + 8'(k))] = data[8*k +: 8];
  endtask

  // ---------------- check / drive helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req_valid  = 1'b0;
    i_addr       = 32'h0;
    i_resp_ready = 1'b1;
    d_req_valid  = 1'b0;
    d_we         = 1'b0;
    d_mode       = 3'b000;
    d_addr       = 32'h0;
    d_wdata      = 32'h0;
    d_resp_ready = 1'b1;
  endtask

  task automatic drive_d(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                         input logic [31:0] wdata);
    d_req_valid = 1'b1;
    d_we        = we;
    d_mode      = mode;
    d_addr      = addr;
    d_wdata     = wdata;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic        dwe;
    logic [2:0]  dmode;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        e_iready;
    logic        e_dready;
    logic        e_we;
    logic [2:0]  e_mode;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_err;
  } vec_t;

  vec_t vecs [9];

  // model state for the random phase
  logic        mi_v, mi_e, md_v, md_e;
  logic [31:0] mi_d, md_d;
  int          last_ok;

  initial begin
    vecs[0] = '{1'b0, 32'h0,  1'b0, 1'b0, 3'b000, 32'h0,  32'h0,    1'b0, 1'b0, 1'b0, 3'b000, 32'h0,  32'h0,    1'b0};
    vecs[1] = '{1'b1, 32'h10, 1'b0, 1'b0, 3'b000, 32'h0,  32'h0,    1'b1, 1'b0, 1'b0, 3'b100, 32'h10, 32'h0,    1'b0};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 3'b100, 32'h40, 32'h55,   1'b0, 1'b1, 1'b0, 3'b100, 32'h40, 32'h55,   1'b0};
    vecs[3] = '{1'b1, 32'h14, 1'b1, 1'b0, 3'b001, 32'h41, 32'h0,    1'b0, 1'b1, 1'b0, 3'b001, 32'h41, 32'h0,    1'b0};
    vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 3'b010, 32'h21, 32'hAAAA, 1'b0, 1'b1, 1'b0, 3'b010, 32'h21, 32'hAAAA, 1'b1};
    vecs[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 3'b011, 32'h80, 32'h1,    1'b0, 1'b1, 1'b0, 3'b011, 32'h80, 32'h1,    1'b1};
    vecs[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 3'b001, 32'h83, 32'h5A,   1'b0, 1'b1, 1'b1, 3'b001, 32'h83, 32'h5A,   1'b0};
    vecs[7] = '{1'b1, 32'h12, 1'b0, 1'b0, 3'b000, 32'h0,  32'h0,    1'b1, 1'b0, 1'b0, 3'b100, 32'h12, 32'h0,    1'b1};
    vecs[8] = '{1'b0, 32'h0,  1'b1, 1'b1, 3'b010, 32'h84, 32'h7777, 1'b0, 1'b1, 1'b1, 3'b010, 32'h84, 32'h7777, 1'b0};

    for (int i = 0; i < 256; i++) shadow[i] = init_byte(i);

    // ---------------- reset state ----------------
    idle_inputs();
    rst = 1'b1;
    i_req_valid = 1'b1;
    i_addr      = 32'h10;
    drive_d(1'b1, 3'b100, 32'h20, 32'h11111111);
    step();
    settle();
    check_bit("rst_i_ready", i_req_ready, 1'b0);
    check_bit("rst_d_ready", d_req_ready, 1'b0);
    check_bit("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_address, 32'h0);
    step();
    settle();
    check_bit("rst_i_resp_valid", i_resp_valid, 1'b0);
    check_bit("rst_d_resp_valid", d_resp_valid, 1'b0);
    check("rst_i_resp_data", i_resp_data, 32'h0);
    check("rst_d_resp_data", d_resp_data, 32'h0);
    check_bit("rst_d_resp_err", d_resp_err, 1'b0);
    check("rst_starve", 32'(dut.starve_cnt), 32'h0);
    step();
    rst = 1'b0;
    idle_inputs();

    // ---------------- single-cycle vector table ----------------
    for (int k = 0; k < 9; k++) begin
      step();
      i_req_valid = vecs[k].iv;
      i_addr      = vecs[k].ia;
      d_req_valid = vecs[k].dv;
      d_we        = vecs[k].dwe;
      d_mode      = vecs[k].dmode;
      d_addr      = vecs[k].da;
      d_wdata     = vecs[k].dwd;
      settle();
      check_bit($sformatf("vec%0d_i_ready", k), i_req_ready, vecs[k].e_iready);
      check_bit($sformatf("vec%0d_d_ready", k), d_req_ready, vecs[k].e_dready);
      check_bit($sformatf("vec%0d_mem_we", k), mem_we, vecs[k].e_we);
      check($sformatf("vec%0d_mem_mode", k), 32'(mem_mode), 32'(vecs[k].e_mode));
      check($sformatf("vec%0d_mem_addr", k), mem_address, vecs[k].e_addr);
      check($sformatf("vec%0d_mem_wdata", k), mem_wdata, vecs[k].e_wdata);
      step();
      idle_inputs();
      settle();
      check_bit($sformatf("vec%0d_i_resp_valid", k), i_resp_valid, vecs[k].e_iready);
      check_bit($sformatf("vec%0d_d_resp_valid", k), d_resp_valid, vecs[k].e_dready);
      if (vecs[k].e_iready) check_bit($sformatf("vec%0d_i_err", k), i_resp_err, vecs[k].e_err);
      if (vecs[k].e_dready) check_bit($sformatf("vec%0d_d_err", k), d_resp_err, vecs[k].e_err);
      if (vecs[k].e_err && vecs[k].e_dready) check($sformatf("vec%0d_d_err_data", k), d_resp_data, 32'h0);
    end

    // ---------------- single fetch ----------------
    step();
    idle_inputs();
    i_req_valid = 1'b1;
    i_addr      = 32'h10;
    settle();
    check_bit("fetch_ready", i_req_ready, 1'b1);
    step();
    idle_inputs();
    settle();
    check_bit("fetch_resp_valid", i_resp_valid, 1'b1);
    check("fetch_resp_data", i_resp_data, 32'h12345678);
    check_bit("fetch_resp_err", i_resp_err, 1'b0);

    // ---------------- write then read ----------------
    step();
    idle_inputs();
    drive_d(1'b1, 3'b100, 32'h20, 32'hDEADBEEF);
    settle();
    check_bit("wr_ready", d_req_ready, 1'b1);
    check_bit("wr_mem_we", mem_we, 1'b1);
    step();
    idle_inputs();
    i_req_valid = 1'b1;
    i_addr      = 32'h20;
    settle();
    check_bit("wr_resp_valid", d_resp_valid, 1'b1);
    check("wr_resp_data", d_resp_data, 32'h0);
    check_bit("wr_resp_err", d_resp_err, 1'b0);
    check_bit("wr_next_fetch_ready", i_req_ready, 1'b1);
    step();
    idle_inputs();
    drive_d(1'b0, 3'b001, 32'h23, 32'h0);
    settle();
    check("wr_next_fetch_data", i_resp_data, 32'hDEADBEEF);
    check_bit("rd_byte_ready", d_req_ready, 1'b1);
    step();
    idle_inputs();
    settle();
    check("rd_byte_data", d_resp_data, 32'hFFFFFFDE);
    check_bit("rd_byte_err", d_resp_err, 1'b0);

    // ---------------- misaligned write ----------------
    step();
    idle_inputs();
    drive_d(1'b1, 3'b010, 32'h21, 32'h1234);
    settle();
    check_bit("mis_ready", d_req_ready, 1'b1);
    check_bit("mis_mem_we", mem_we, 1'b0);
    step();
    idle_inputs();
    settle();
    check_bit("mis_resp_valid", d_resp_valid, 1'b1);
    check_bit("mis_resp_err", d_resp_err, 1'b1);
    check("mis_resp_data", d_resp_data, 32'h0);
    check("mis_mem_21", 32'(phys[8'h21]), 32'hBE);
    check("mis_mem_22", 32'(phys[8'h22]), 32'hAD);

    // ---------------- both ports requesting continuously ----------------
    // The single response slot makes a port ineligible the cycle after its grant,
    // so continuous contention settles into data / fetch alternation.
    step();
    idle_inputs();
    step();
    i_req_valid = 1'b1;
    i_addr      = 32'h30;
    drive_d(1'b0, 3'b100, 32'h40, 32'h0);
    for (int c = 0; c < 12; c++) begin
      settle();
      check_bit($sformatf("contend%0d_d_ready", c), d_req_ready, (c % 2) == 0);
      check_bit($sformatf("contend%0d_i_ready", c), i_req_ready, (c % 2) == 1);
      step();
    end
    idle_inputs();

    // ---------------- data response backpressure ----------------
    step();
    step();
    drive_d(1'b0, 3'b100, 32'h20, 32'h0);
    d_resp_ready = 1'b0;
    settle();
    check_bit("bp_accept", d_req_ready, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      step();
      i_req_valid  = 1'b1;
      i_addr       = 32'h10;
      i_resp_ready = 1'b1;
      d_resp_ready = 1'b0;
      settle();
      check_bit($sformatf("bp%0d_d_valid", c), d_resp_valid, 1'b1);
      check($sformatf("bp%0d_d_data", c), d_resp_data, 32'hDEADBEEF);
      check_bit($sformatf("bp%0d_d_err", c), d_resp_err, 1'b0);
      check_bit($sformatf("bp%0d_d_ready", c), d_req_ready, 1'b0);
      check_bit($sformatf("bp%0d_i_ready", c), i_req_ready, (c % 2) == 1);
      if (c % 2 == 0) check($sformatf("bp%0d_i_data", c), i_resp_data, 32'h12345678);
    end
    step();
    idle_inputs();
    settle();
    check_bit("bp_release_valid", d_resp_valid, 1'b1);
    step();
    settle();
    check_bit("bp_cleared", d_resp_valid, 1'b0);

    // ---------------- reset mid-flight ----------------
    step();
    i_req_valid = 1'b1;
    i_addr      = 32'h14;
    drive_d(1'b0, 3'b100, 32'h10, 32'h0);
    d_resp_ready = 1'b0;
    settle();
    check_bit("mf_accept", d_req_ready, 1'b1);
    step();
    rst = 1'b1;
    drive_d(1'b1, 3'b100, 32'h10, 32'hCAFEF00D);
    for (int c = 0; c < 2; c++) begin
      settle();
      check_bit($sformatf("mf_rst%0d_d_ready", c), d_req_ready, 1'b0);
      check_bit($sformatf("mf_rst%0d_i_ready", c), i_req_ready, 1'b0);
      check_bit($sformatf("mf_rst%0d_mem_we", c), mem_we, 1'b0);
      check_bit($sformatf("mf_rst%0d_d_valid", c), d_resp_valid, 1'b0);
      if (c == 0) step();
    end
    step();
    rst = 1'b0;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      settle();
      check_bit($sformatf("mf_after%0d_d_valid", c), d_resp_valid, 1'b0);
      check_bit($sformatf("mf_after%0d_i_valid", c), i_resp_valid, 1'b0);
      step();
    end
    check("mf_starve", 32'(dut.starve_cnt), 32'h0);
    check("mf_mem_word", {phys[8'h13], phys[8'h12], phys[8'h11], phys[8'h10]}, 32'h12345678);

    // ---------------- randomized traffic against the model ----------------
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = phys[i];
    mi_v = 1'b0; mi_e = 1'b0; mi_d = 32'h0;
    md_v = 1'b0; md_e = 1'b0; md_d = 32'h0;
    last_ok = -1;
    for (int cyc = 0; cyc < N_RAND; cyc++) begin
      logic        ie, de, gi, gd, imis, dmis, e_we;
      logic [2:0]  e_mode;
      logic [31:0] e_addr, e_wdata;
      int          starve;
      int          r;
      step();
      rst          = ($urandom_range(0, 99) == 0);
      i_req_valid  = ($urandom_range(0, 3) != 0);
      i_addr       = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : ($urandom_range(0, 63) << 2);
      i_resp_ready = ($urandom_range(0, 3) != 0);
      d_req_valid  = ($urandom_range(0, 3) != 0);
      d_we         = ($urandom_range(0, 1) == 1);
      r = int'($urandom_range(0, 7));
      d_mode       = (r < 2) ? 3'b001 : (r < 4) ? 3'b010 : (r < 6) ? 3'b100 : 3'($urandom_range(0, 7));
      d_addr       = $urandom_range(0, 255);
      d_wdata      = $urandom;
      d_resp_ready = ($urandom_range(0, 3) != 0);
      settle();

      ie     = !rst && i_req_valid && !mi_v;
      de     = !rst && d_req_valid && !md_v;
      starve = cyc - 1 - last_ok;
      if (starve > int'(STARVE)) starve = int'(STARVE);
      gi     = ie && (!de || starve >= int'(STARVE));
      gd     = de && !gi;
      imis   = model_mis(i_addr, 3'b100);
      dmis   = model_mis(d_addr, d_mode);
      e_we = 1'b0; e_mode = 3'b000; e_addr = 32'h0; e_wdata = 32'h0;
      if (gi) begin
        e_mode = 3'b100; e_addr = i_addr;
      end else if (gd) begin
        e_mode = d_mode; e_addr = d_addr; e_wdata = d_wdata; e_we = d_we && !dmis;
      end

      check_bit("rnd_i_ready", i_req_ready, gi);
      check_bit("rnd_d_ready", d_req_ready, gd);
      check_bit("rnd_mem_we", mem_we, e_we);
      check("rnd_mem_mode", 32'(mem_mode), 32'(e_mode));
      check("rnd_mem_addr", mem_address, e_addr);
      check("rnd_mem_wdata", mem_wdata, e_wdata);
      check_bit("rnd_i_resp_valid", i_resp_valid, mi_v && !rst);
      check_bit("rnd_d_resp_valid", d_resp_valid, md_v && !rst);
      if (mi_v && !rst) begin
        check("rnd_i_resp_data", i_resp_data, mi_d);
        check_bit("rnd_i_resp_err", i_resp_err, mi_e);
      end
      if (md_v && !rst) begin
        check("rnd_d_resp_data", d_resp_data, md_d);
        check_bit("rnd_d_resp_err", d_resp_err, md_e);
      end

      if (rst) begin
        mi_v = 1'b0;
        md_v = 1'b0;
        last_ok = cyc;
      end else begin
        if (gi) begin
          mi_v = 1'b1; mi_e = imis; mi_d = imis ? 32'h0 : shadow_read(i_addr, 3'b100);
        end else if (mi_v && i_resp_ready) begin
          mi_v = 1'b0;
        end
        if (gd) begin
          md_v = 1'b1; md_e = dmis;
          md_d = (dmis || d_we) ? 32'h0 : shadow_read(d_addr, d_mode);
          if (d_we && !dmis) shadow_write(d_addr, d_mode, d_wdata);
        end else if (md_v && d_resp_ready) begin
          md_v = 1'b0;
        end
        if (!(ie && !gi)) last_ok = cyc;
      end
    end

    step();
    idle_inputs();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
